// File: rtl/discrete_sizes_table_writer.sv
// discrete_sizes_table_writer
//   Writer side of the discrete-variable size table. A host streams one count
//   per variable over a valid/ready handshake after an in_start pulse; the
//   block saturates oversized counts, owns the table storage and serves the
//   randomizer read port (index in, registered count out, 1-cycle latency).
//
//   Handshake: a word moves on a rising edge when in_data_valid and
//   out_data_ready are both high on that edge, unless in_start is also high
//   (a restart always wins and the word is dropped). out_data_ready is a
//   registered output, high only while loading.
//
//   Optional feature macro: DISCRETE_TABLE_CHECKSUM_EN
//     Defined: each load takes NUM_VARS+1 words; the last word is the sum of
//     the raw data words mod 2^SIZE_W. It is not stored; a mismatch raises
//     out_error and keeps out_table_valid low (out_load_done still pulses).
//     Undefined: exactly NUM_VARS words per load, no checksum logic.
//
//   out_debug_state exposes the FSM state (0=IDLE, 1=LOAD, 2=DONE).
module discrete_sizes_table_writer #(
  parameter int NUM_VARS   = 4,
  parameter int IDX_W      = 2,
  parameter int SIZE_W     = 3,
  parameter int MAX_VALUES = 4
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_start,
  input  logic              in_data_valid,
  input  logic [SIZE_W-1:0] in_data,
  output logic              out_data_ready,
  output logic              out_load_done,
  output logic              out_table_valid,
  output logic              out_error,
  input  logic [IDX_W-1:0]  in_variable_index,
  output logic [SIZE_W-1:0] out_number_of_discrete_assignments,
  output logic [1:0]        out_debug_state
);

`ifdef DISCRETE_TABLE_CHECKSUM_EN
  localparam int WORDS = NUM_VARS + 1;
`else
  localparam int WORDS = NUM_VARS;
`endif

  // Counter must reach WORDS so it can index every stream word.
  localparam int CNT_W = $clog2(WORDS + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(NUM_VARS);
  localparam logic [SIZE_W-1:0] MAX_ENTRY  = SIZE_W'(MAX_VALUES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                ready_q;
  logic                done_q;
  logic                tvalid_q;
  logic                err_q;
  logic [SIZE_W-1:0]   rd_q;
  logic [SIZE_W-1:0]   table_q [NUM_VARS];

  logic                xfer;
  logic                last_xfer;
  logic                table_wr;
  logic                sat;
  logic [SIZE_W-1:0]   wr_value;

`ifdef DISCRETE_TABLE_CHECKSUM_EN
  logic [SIZE_W-1:0]   sum_q;
`endif

  // FSM state register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; a restart suppresses any transfer.
  always_comb begin
    state_d   = state_q;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        xfer      = in_data_valid & ready_q & ~in_start;
        last_xfer = xfer & (cnt_q == LAST_CNT);
        if (in_start)       state_d = ST_LOAD;
        else if (last_xfer) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = in_start ? ST_LOAD : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only data words land in the table; the checksum word never does.
  assign table_wr = xfer & (cnt_q < DEPTH_CNT);
  assign sat      = in_data > MAX_ENTRY;
  assign wr_value = sat ? MAX_ENTRY : in_data;

  // Load control: counter, sticky error, table-valid, done pulse, ready.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      tvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= (state_d == ST_LOAD);
      done_q  <= (state_d == ST_DONE);
      if (in_start) begin
        cnt_q    <= '0;
        tvalid_q <= 1'b0;
        err_q    <= 1'b0;
      end else if (xfer) begin
        cnt_q <= cnt_q + 1'b1;
        if (table_wr && sat) err_q <= 1'b1;
`ifdef DISCRETE_TABLE_CHECKSUM_EN
        if (last_xfer) begin
          if (in_data != sum_q) err_q    <= 1'b1;
          else                  tvalid_q <= 1'b1;
        end
`else
        if (last_xfer) tvalid_q <= 1'b1;
`endif
      end
    end
  end

`ifdef DISCRETE_TABLE_CHECKSUM_EN
  // Running checksum of raw (unsaturated) data words, mod 2^SIZE_W.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sum_q <= '0;
    end else if (in_start) begin
      sum_q <= '0;
    end else if (table_wr) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

  // Table storage; cleared by reset, written one entry per accepted word.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < NUM_VARS; i++) table_q[i] <= '0;
    end else if (table_wr) begin
      table_q[cnt_q[IDX_W-1:0]] <= wr_value;
    end
  end

  // Registered read port; sees the pre-write value on a same-edge write.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rd_q <= '0;
    end else if (32'(in_variable_index) < NUM_VARS) begin
      rd_q <= table_q[in_variable_index];
    end else begin
      rd_q <= '0;
    end
  end

  assign out_data_ready                     = ready_q;
  assign out_load_done                      = done_q;
  assign out_table_valid                    = tvalid_q;
  assign out_error                          = err_q;
  assign out_number_of_discrete_assignments = rd_q;
  assign out_debug_state                    = state_q;

endmodule

// File: tb/tb_discrete_sizes_table_writer.sv
// Bench for discrete_sizes_table_writer: directed load scenarios followed by
// randomized traffic, all checked against a transaction-level table model.
module tb_discrete_sizes_table_writer;

  localparam int N    = 4;
  localparam int MAXV = 4;
`ifdef DISCRETE_TABLE_CHECKSUM_EN
  localparam int WORDS = N + 1;
`else
  localparam int WORDS = N;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       data_valid;
  logic [2:0] data;
  logic       data_ready;
  logic       load_done;
  logic       table_valid;
  logic       error;
  logic [1:0] var_idx;
  logic [2:0] rd_data;
  logic [1:0] debug_state;

  discrete_sizes_table_writer dut (
    .in_clk                             (clk),
    .in_rst_n                           (rst_n),
    .in_start                           (start),
    .in_data_valid                      (data_valid),
    .in_data                            (data),
    .out_data_ready                     (data_ready),
    .out_load_done                      (load_done),
    .out_table_valid                    (table_valid),
    .out_error                          (error),
    .in_variable_index                  (var_idx),
    .out_number_of_discrete_assignments (rd_data),
    .out_debug_state                    (debug_state)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what a host would expect from the table after each edge.
  int  m_table [N];
  bit  m_loading;   // a load is in progress and words are being accepted
  bit  m_done;      // the load finished on the last edge
  int  m_cnt;       // words accepted in the current load
  int  m_sum;
  bit  m_err;
  bit  m_tvalid;
  int  m_rd;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_table[i] = 0;
    m_loading = 0; m_done = 0; m_cnt = 0; m_sum = 0;
    m_err = 0; m_tvalid = 0; m_rd = 0;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  function automatic void model_edge(input bit s, input bit v, input int d, input int ix);
    bit accept;
    m_rd   = (ix < N) ? m_table[ix] : 0;
    accept = v && m_loading && !s;
    m_done = 0;
    if (s) begin
      m_loading = 1; m_cnt = 0; m_sum = 0; m_err = 0; m_tvalid = 0;
    end else if (accept) begin
      if (m_cnt < N) begin
        m_table[m_cnt] = (d > MAXV) ? MAXV : d;
        if (d > MAXV) m_err = 1;
        m_sum = (m_sum + d) % 8;
        m_cnt++;
        if (m_cnt == WORDS) begin
          m_loading = 0; m_done = 1; m_tvalid = 1;
        end
      end else begin
        if (d != m_sum) m_err = 1;
        else            m_tvalid = 1;
        m_loading = 0; m_done = 1;
      end
    end
  endfunction

  task automatic check_outputs();
    check_eq("data_ready",  int'(data_ready),  int'(m_loading));
    check_eq("load_done",   int'(load_done),   int'(m_done));
    check_eq("table_valid", int'(table_valid), int'(m_tvalid));
    check_eq("error",       int'(error),       int'(m_err));
    check_eq("read_data",   int'(rd_data),     m_rd);
  endtask

  // Driver: check the previous edge's results, then present one cycle of inputs.
  task automatic step(input bit s, input bit v, input int d, input int ix);
    @(negedge clk);
    check_outputs();
    start      = s;
    data_valid = v;
    data       = 3'(d);
    var_idx    = 2'(ix);
    model_edge(s, v, d, ix);
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0; data_valid = 1'b0; data = '0; var_idx = '0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stream a word list with valid held (gap=0) or toggling (gap=1).
  task automatic stream(input int w0, input int w1, input int w2, input int w3, input bit gap);
    int w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      if (gap) step(0, 0, $urandom_range(0, 7), i);
      step(0, 1, w[i], i);
    end
  endtask

  task automatic send_checksum(input int w0, input int w1, input int w2, input int w3);
`ifdef DISCRETE_TABLE_CHECKSUM_EN
    step(0, 1, (w0 + w1 + w2 + w3) % 8, 0);
`else
    step(0, 0, w0 + w1 + w2 + w3 - (w0 + w1 + w2 + w3), 0);
`endif
  endtask

  // Read one entry and compare against a spec-derived constant.
  task automatic read_expect(input int ix, input int exp);
    step(0, 0, 0, ix);
    @(posedge clk);
    #1;
    check_eq("table_entry", int'(rd_data), exp);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; data_valid = 1'b0; data = '0; var_idx = '0;
    do_reset();

    // Basic load, valid held; reads track the written index (read-before-write).
    step(1, 0, 0, 0);
    stream(3, 2, 0, 4, 0);
    send_checksum(3, 2, 0, 4);
    step(0, 0, 0, 0);
    read_expect(0, 3); read_expect(1, 2); read_expect(2, 0); read_expect(3, 4);

    // Same table via a toggling valid.
    step(1, 0, 0, 0);
    stream(3, 2, 0, 4, 1);
    send_checksum(3, 2, 0, 4);
    step(0, 0, 0, 0);
    read_expect(2, 0); read_expect(3, 4);

    // Saturation; the next start clears the sticky error.
    step(1, 0, 0, 0);
    stream(7, 1, 1, 1, 0);
    send_checksum(7, 1, 1, 1);
    step(0, 0, 0, 0);
    read_expect(0, 4);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Restart mid-load, including a start that collides with a transfer.
    step(0, 1, 5, 0);
    step(0, 1, 5, 1);
    step(1, 1, 6, 2);
    stream(1, 1, 1, 1, 0);
    send_checksum(1, 1, 1, 1);
    step(0, 0, 0, 0);
    read_expect(2, 1); read_expect(0, 1);

    // Write index 2 with an old value of 0 while reading it on the same edge.
    step(1, 0, 0, 0);
    stream(2, 2, 0, 2, 0);
    send_checksum(2, 2, 0, 2);
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    step(0, 1, 3, 2);
    step(0, 0, 0, 2);

    // Asynchronous reset in the middle of a load.
    step(1, 0, 0, 0);
    step(0, 1, 3, 0);
    step(0, 1, 3, 1);
    do_reset();
    read_expect(0, 0); read_expect(1, 0);
    step(0, 1, 2, 0);

`ifdef DISCRETE_TABLE_CHECKSUM_EN
    // Good and bad checksum words.
    step(1, 0, 0, 0);
    stream(3, 2, 0, 4, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    stream(3, 2, 0, 4, 0);
    step(0, 1, 2, 0);
    step(0, 0, 0, 0);
`endif

    // Randomized traffic with occasional restarts and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3));
      end
    end
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
